// File: rtl/mem_iss_arb.sv
// -----------------------------------------------------------------------------
// mem_iss_arb
//   Arbitrates the single memory bus between the D-cache MSHR issue-queue head
//   and I-cache miss requests. A winner is latched into a one-entry issue slot
//   and driven onto the bus from registers. The slot is retried each cycle until
//   memory answers with a non-zero acceptance tag; the owner is then acked with
//   that tag. Accepted BUS_LOADs awaiting data are counted and capped at
//   MAX_OUTSTD.
//
// Configuration macro:
//   MEM_ISS_RR_EN  defined   -> IDLE ties alternate away from the last winner
//                  undefined -> fixed priority, D-cache always wins ties
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   mshr_iss_*_i           D-cache MSHR issue head (valid, tag, idx, data, message, head ptr)
//   mshr_iss_ack_o         pulse: head retired
//   mshr_rsp_vld_o/tag_o   pulse with ack when the retired op was a BUS_LOAD, plus its tag
//   mshr_rsp_head_o        MSHR head pointer the tag belongs to
//   ic_req_en_i/addr_i     I-cache miss request (level) and block address
//   ic_gnt_o/ic_rsp_tag_o  pulse: I-cache request accepted, plus its tag
//   proc2mem_*_o           registered bus command/address/store data
//   mem2proc_response_i    same-cycle acceptance tag (0 = rejected)
//   mem2proc_tag_i         data-return tag (non-zero retires one outstanding load)
//   outstd_cnt_o           accepted loads awaiting data
//
// message encoding on mshr_iss_message_i: 0 NONE, 1 GET_S, 2 GET_M, 3 PUT_M
// bus command encoding: 0 BUS_NONE, 1 BUS_LOAD, 2 BUS_STORE
// -----------------------------------------------------------------------------

`ifndef DCACHE_TAG_W
`define DCACHE_TAG_W 8
`endif
`ifndef DCACHE_IDX_W
`define DCACHE_IDX_W 5
`endif
`ifndef MSHR_IDX_W
`define MSHR_IDX_W 3
`endif

module mem_iss_arb #(
    parameter int unsigned MEM_TAG_W  = 4,
    parameter int unsigned MAX_OUTSTD = 15,
    localparam int unsigned CNT_W     = $clog2(MAX_OUTSTD + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mshr_iss_en_i,
    input  logic [`DCACHE_TAG_W-1:0] mshr_iss_tag_i,
    input  logic [`DCACHE_IDX_W-1:0] mshr_iss_idx_i,
    input  logic [63:0]              mshr_iss_data_i,
    input  logic [1:0]               mshr_iss_message_i,
    input  logic [`MSHR_IDX_W-1:0]   mshr_iss_head_i,
    output logic                     mshr_iss_ack_o,
    output logic                     mshr_rsp_vld_o,
    output logic [MEM_TAG_W-1:0]     mshr_rsp_tag_o,
    output logic [`MSHR_IDX_W-1:0]   mshr_rsp_head_o,
    input  logic                     ic_req_en_i,
    input  logic [63:0]              ic_req_addr_i,
    output logic                     ic_gnt_o,
    output logic [MEM_TAG_W-1:0]     ic_rsp_tag_o,
    output logic [1:0]               proc2mem_command_o,
    output logic [63:0]              proc2mem_addr_o,
    output logic [63:0]              proc2mem_data_o,
    input  logic [MEM_TAG_W-1:0]     mem2proc_response_i,
    input  logic [MEM_TAG_W-1:0]     mem2proc_tag_i,
    output logic [CNT_W-1:0]         outstd_cnt_o
);

    localparam logic [1:0] MSG_NONE  = 2'd0;
    localparam logic [1:0] MSG_GET_S = 2'd1;
    localparam logic [1:0] MSG_GET_M = 2'd2;
    localparam logic [1:0] MSG_PUT_M = 2'd3;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic OWN_D  = 1'b0;
    localparam logic OWN_IC = 1'b1;

    localparam int unsigned PAD_W = 64 - `DCACHE_TAG_W - `DCACHE_IDX_W - 3;

    // Issue slot; cmd/addr/data double as the bus-driving registers
    logic [0:0]             r_state;
    logic                   r_owner;
    logic [1:0]             r_cmd;
    logic [63:0]            r_addr;
    logic [63:0]            r_data;
    logic [`MSHR_IDX_W-1:0] r_head;

    logic                   r_mshr_ack;
    logic                   r_ic_gnt;
    logic                   r_rsp_vld;
    logic [MEM_TAG_W-1:0]   r_rsp_tag;
    logic [CNT_W-1:0]       r_outstd_cnt;

    logic                   w_full;
    logic                   w_d_is_load;
    logic                   w_d_elig;
    logic                   w_ic_elig;
    logic                   w_bubble;
    logic                   w_pick_ic;
    logic                   w_start;
    logic                   w_drain;
    logic                   w_accept;
    logic                   w_inc;
    logic                   w_dec;
    logic [1:0]             w_slot_cmd;
    logic [63:0]            w_slot_addr;
    logic [63:0]            w_slot_data;
    logic [63:0]            w_d_addr;
    logic [CNT_W-1:0]       w_cnt_d;

    assign w_full      = (r_outstd_cnt == CNT_W'(MAX_OUTSTD));
    assign w_d_is_load = (mshr_iss_message_i == MSG_GET_S) || (mshr_iss_message_i == MSG_GET_M);
    assign w_d_elig    = mshr_iss_en_i && !(w_d_is_load && w_full);
    assign w_ic_elig   = ic_req_en_i && !w_full;

    // An ack issued last cycle pops the MSHR head only now; skip sampling the stale head.
    assign w_bubble = r_mshr_ack | r_ic_gnt;

`ifdef MEM_ISS_RR_EN
    logic r_rr_last;

    assign w_pick_ic = w_ic_elig && (!w_d_elig || (r_rr_last == OWN_D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= OWN_IC;
        end else if (w_accept) begin
            r_rr_last <= r_owner;
        end
    end
`else
    assign w_pick_ic = w_ic_elig && !w_d_elig;
`endif

    assign w_start  = (r_state == ST_IDLE) && !w_bubble && (w_d_elig || w_ic_elig);
    assign w_drain  = w_start && !w_pick_ic && (mshr_iss_message_i == MSG_NONE);
    assign w_accept = (r_state == ST_ISSUE) && (mem2proc_response_i != '0);

    assign w_d_addr = {{PAD_W{1'b0}}, mshr_iss_tag_i, mshr_iss_idx_i, 3'b000};

    always_comb begin
        w_slot_cmd  = BUS_LOAD;
        w_slot_addr = ic_req_addr_i;
        w_slot_data = '0;
        if (!w_pick_ic) begin
            w_slot_addr = w_d_addr;
            if (mshr_iss_message_i == MSG_PUT_M) begin
                w_slot_cmd  = BUS_STORE;
                w_slot_data = mshr_iss_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_D;
            r_cmd      <= BUS_NONE;
            r_addr     <= '0;
            r_data     <= '0;
            r_head     <= '0;
            r_mshr_ack <= 1'b0;
            r_ic_gnt   <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_rsp_tag  <= '0;
        end else begin
            r_mshr_ack <= 1'b0;
            r_ic_gnt   <= 1'b0;
            r_rsp_vld  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_drain) begin
                        r_mshr_ack <= 1'b1;
                        r_rsp_tag  <= '0;
                        r_head     <= mshr_iss_head_i;
                    end else if (w_start) begin
                        r_state <= ST_ISSUE;
                        r_owner <= w_pick_ic ? OWN_IC : OWN_D;
                        r_cmd   <= w_slot_cmd;
                        r_addr  <= w_slot_addr;
                        r_data  <= w_slot_data;
                        r_head  <= mshr_iss_head_i;
                    end
                end
                ST_ISSUE: begin
                    // Rejected responses leave the slot on the bus for another try
                    if (w_accept) begin
                        r_state   <= ST_IDLE;
                        r_cmd     <= BUS_NONE;
                        r_rsp_tag <= mem2proc_response_i;
                        if (r_owner == OWN_IC) begin
                            r_ic_gnt <= 1'b1;
                        end else begin
                            r_mshr_ack <= 1'b1;
                            r_rsp_vld  <= (r_cmd == BUS_LOAD);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outstanding-load counter: saturating, simultaneous inc/dec cancel
    assign w_inc = w_accept && (r_cmd == BUS_LOAD);
    assign w_dec = (mem2proc_tag_i != '0) && (r_outstd_cnt != '0);

    always_comb begin
        w_cnt_d = r_outstd_cnt;
        if (w_inc && !w_dec) begin
            if (!w_full) begin
                w_cnt_d = r_outstd_cnt + CNT_W'(1);
            end
        end else if (w_dec && !w_inc) begin
            w_cnt_d = r_outstd_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstd_cnt <= '0;
        end else begin
            r_outstd_cnt <= w_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !((mem2proc_tag_i != '0) && (r_outstd_cnt == '0)));
`endif

    assign mshr_iss_ack_o     = r_mshr_ack;
    assign mshr_rsp_vld_o     = r_rsp_vld;
    assign mshr_rsp_tag_o     = r_rsp_tag;
    assign mshr_rsp_head_o    = r_head;
    assign ic_gnt_o           = r_ic_gnt;
    assign ic_rsp_tag_o       = r_rsp_tag;
    assign proc2mem_command_o = r_cmd;
    assign proc2mem_addr_o    = r_addr;
    assign proc2mem_data_o    = r_data;
    assign outstd_cnt_o       = r_outstd_cnt;

endmodule

// File: tb/tb_mem_iss_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_iss_arb
//   Scoreboard bench for mem_iss_arb. Each request pushed to a requester queue
//   also pushes its expected completion (owner, bus op, memory tag, reject count,
//   latency) to exp_q in the order completions must occur. A negedge service
//   loop presents requester heads, plays memory, and pops/compares on each ack.
// -----------------------------------------------------------------------------

`ifndef DCACHE_TAG_W
`define DCACHE_TAG_W 8
`endif
`ifndef DCACHE_IDX_W
`define DCACHE_IDX_W 5
`endif
`ifndef MSHR_IDX_W
`define MSHR_IDX_W 3
`endif

module tb_mem_iss_arb;

    localparam int TW = `DCACHE_TAG_W;
    localparam int IW = `DCACHE_IDX_W;
    localparam int HW = `MSHR_IDX_W;
    localparam int MTW = 4;

    localparam logic [1:0] MSG_NONE  = 2'd0;
    localparam logic [1:0] MSG_GET_S = 2'd1;
    localparam logic [1:0] MSG_GET_M = 2'd2;
    localparam logic [1:0] MSG_PUT_M = 2'd3;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic            clk;
    logic            rst;
    logic            mshr_iss_en_i;
    logic [TW-1:0]   mshr_iss_tag_i;
    logic [IW-1:0]   mshr_iss_idx_i;
    logic [63:0]     mshr_iss_data_i;
    logic [1:0]      mshr_iss_message_i;
    logic [HW-1:0]   mshr_iss_head_i;
    logic            mshr_iss_ack_o;
    logic            mshr_rsp_vld_o;
    logic [MTW-1:0]  mshr_rsp_tag_o;
    logic [HW-1:0]   mshr_rsp_head_o;
    logic            ic_req_en_i;
    logic [63:0]     ic_req_addr_i;
    logic            ic_gnt_o;
    logic [MTW-1:0]  ic_rsp_tag_o;
    logic [1:0]      proc2mem_command_o;
    logic [63:0]     proc2mem_addr_o;
    logic [63:0]     proc2mem_data_o;
    logic [MTW-1:0]  mem2proc_response_i;
    logic [MTW-1:0]  mem2proc_tag_i;
    logic [3:0]      outstd_cnt_o;

    mem_iss_arb #(
        .MEM_TAG_W (MTW),
        .MAX_OUTSTD(15)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .mshr_iss_en_i      (mshr_iss_en_i),
        .mshr_iss_tag_i     (mshr_iss_tag_i),
        .mshr_iss_idx_i     (mshr_iss_idx_i),
        .mshr_iss_data_i    (mshr_iss_data_i),
        .mshr_iss_message_i (mshr_iss_message_i),
        .mshr_iss_head_i    (mshr_iss_head_i),
        .mshr_iss_ack_o     (mshr_iss_ack_o),
        .mshr_rsp_vld_o     (mshr_rsp_vld_o),
        .mshr_rsp_tag_o     (mshr_rsp_tag_o),
        .mshr_rsp_head_o    (mshr_rsp_head_o),
        .ic_req_en_i        (ic_req_en_i),
        .ic_req_addr_i      (ic_req_addr_i),
        .ic_gnt_o           (ic_gnt_o),
        .ic_rsp_tag_o       (ic_rsp_tag_o),
        .proc2mem_command_o (proc2mem_command_o),
        .proc2mem_addr_o    (proc2mem_addr_o),
        .proc2mem_data_o    (proc2mem_data_o),
        .mem2proc_response_i(mem2proc_response_i),
        .mem2proc_tag_i     (mem2proc_tag_i),
        .outstd_cnt_o       (outstd_cnt_o)
    );

    typedef struct {
        logic [1:0]    msg;
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
        logic [63:0]   data;
        logic [HW-1:0] head;
    } d_req_t;

    typedef struct {
        logic           owner;   // 0 = D-cache, 1 = I-cache
        logic [1:0]     cmd;     // BUS_NONE for a drained NONE head
        logic [63:0]    addr;
        logic [63:0]    data;
        logic [HW-1:0]  head;
        logic           rsp_vld;
        logic [MTW-1:0] mtag;    // tag memory will hand out on acceptance
        int             rej;     // rejections before acceptance
        int             lat;     // expected request-to-ack cycles, 0 = unchecked
    } exp_t;

    d_req_t      d_q[$];
    logic [63:0] i_q[$];
    exp_t        exp_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int bus_cyc = 0;
    int rej_done = 0;
    int d_pres_cyc = 0;
    int i_pres_cyc = 0;
    bit d_pres = 0;
    bit i_pres = 0;

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] d_addr(input logic [TW-1:0] tag, input logic [IW-1:0] idx);
        return (64'(tag) << (IW + 3)) | (64'(idx) << 3);
    endfunction

    task automatic push_d(input logic [1:0] msg, input logic [TW-1:0] tag,
                          input logic [IW-1:0] idx, input logic [63:0] data,
                          input logic [HW-1:0] head, input int rej,
                          input logic [MTW-1:0] mtag, input int lat);
        d_req_t r;
        exp_t   e;
        r.msg = msg; r.tag = tag; r.idx = idx; r.data = data; r.head = head;
        d_q.push_back(r);
        e.owner   = 1'b0;
        e.cmd     = (msg == MSG_NONE) ? BUS_NONE : (msg == MSG_PUT_M) ? BUS_STORE : BUS_LOAD;
        e.addr    = d_addr(tag, idx);
        e.data    = data;
        e.head    = head;
        e.rsp_vld = (msg == MSG_GET_S) || (msg == MSG_GET_M);
        e.mtag    = mtag;
        e.rej     = rej;
        e.lat     = lat;
        exp_q.push_back(e);
    endtask

    task automatic push_i(input logic [63:0] addr, input int rej, input logic [MTW-1:0] mtag,
                          input int lat);
        exp_t e;
        i_q.push_back(addr);
        e.owner = 1'b1; e.cmd = BUS_LOAD; e.addr = addr; e.data = '0; e.head = '0;
        e.rsp_vld = 1'b0; e.mtag = mtag; e.rej = rej; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Runs at every negedge: retire acks, present requester heads, play memory.
    task automatic service();
        exp_t e;
        if (mshr_iss_ack_o || ic_gnt_o) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_ack", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("ack_owner", 64'(ic_gnt_o), 64'(e.owner));
                check_eq("ack_exclusive", 64'(mshr_iss_ack_o & ic_gnt_o), 64'(0));
                check_eq("rsp_vld", 64'(mshr_rsp_vld_o), 64'(e.rsp_vld));
                if (e.owner) begin
                    check_eq("ic_tag", 64'(ic_rsp_tag_o), 64'(e.mtag));
                end else if (e.rsp_vld) begin
                    check_eq("mshr_tag", 64'(mshr_rsp_tag_o), 64'(e.mtag));
                    check_eq("mshr_head", 64'(mshr_rsp_head_o), 64'(e.head));
                end
                check_eq("bus_cycles", 64'(bus_cyc), 64'((e.cmd == BUS_NONE) ? 0 : e.rej + 1));
                if (e.lat != 0) begin
                    check_eq("latency", 64'(cyc - (e.owner ? i_pres_cyc : d_pres_cyc)),
                             64'(e.lat));
                end
            end
            bus_cyc  = 0;
            rej_done = 0;
            if (mshr_iss_ack_o && d_q.size() > 0) begin
                void'(d_q.pop_front());
                d_pres = 0;
            end
            if (ic_gnt_o && i_q.size() > 0) begin
                void'(i_q.pop_front());
                i_pres = 0;
            end
        end

        mshr_iss_en_i = (d_q.size() > 0);
        if (d_q.size() > 0) begin
            mshr_iss_message_i = d_q[0].msg;
            mshr_iss_tag_i     = d_q[0].tag;
            mshr_iss_idx_i     = d_q[0].idx;
            mshr_iss_data_i    = d_q[0].data;
            mshr_iss_head_i    = d_q[0].head;
            if (!d_pres) begin
                d_pres     = 1;
                d_pres_cyc = cyc;
            end
        end
        ic_req_en_i = (i_q.size() > 0);
        if (i_q.size() > 0) begin
            ic_req_addr_i = i_q[0];
            if (!i_pres) begin
                i_pres     = 1;
                i_pres_cyc = cyc;
            end
        end

        mem2proc_response_i = '0;
        if (proc2mem_command_o != BUS_NONE) begin
            bus_cyc++;
            if (exp_q.size() == 0) begin
                check_eq("bus_unexpected", 64'(proc2mem_command_o), 64'(BUS_NONE));
            end else if (rej_done < exp_q[0].rej) begin
                rej_done++;
            end else begin
                check_eq("bus_cmd", 64'(proc2mem_command_o), 64'(exp_q[0].cmd));
                check_eq("bus_addr", proc2mem_addr_o, exp_q[0].addr);
                if (exp_q[0].cmd == BUS_STORE) begin
                    check_eq("bus_data", proc2mem_data_o, exp_q[0].data);
                end
                mem2proc_response_i = exp_q[0].mtag;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #1;
        check_eq(name, 64'(exp_q.size()), 64'(0));
        if (exp_q.size() > 0) begin
            exp_q.delete();
            d_q.delete();
            i_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        bus_cyc  = 0;
        rej_done = 0;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        mshr_iss_en_i = 0; mshr_iss_tag_i = '0; mshr_iss_idx_i = '0; mshr_iss_data_i = '0;
        mshr_iss_message_i = MSG_NONE; mshr_iss_head_i = '0;
        ic_req_en_i = 0; ic_req_addr_i = '0; mem2proc_response_i = '0;
        forever begin
            @(negedge clk);
            service();
        end
    end

    initial begin
        rst = 1'b1;
        mem2proc_tag_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd", 64'(proc2mem_command_o), 64'(BUS_NONE));
        check_eq("rst_addr", proc2mem_addr_o, 64'(0));
        check_eq("rst_data", proc2mem_data_o, 64'(0));
        check_eq("rst_cnt", 64'(outstd_cnt_o), 64'(0));
        check_eq("rst_pulses", 64'({mshr_iss_ack_o, mshr_rsp_vld_o, ic_gnt_o}), 64'(0));
        #1 rst = 1'b0;

        // 1: GET_S accepted on the first ISSUE cycle
        @(posedge clk); #1;
        push_d(MSG_GET_S, 8'h12, 5'h03, 64'h0, 3'd2, 0, 4'd5, 2);
        wait_drain("t1_done", 20);
        check_eq("t1_cnt", 64'(outstd_cnt_o), 64'(1));

        // 2: PUT_M rejected three times
        push_d(MSG_PUT_M, 8'h34, 5'h1a, 64'hDEAD_BEEF, 3'd3, 3, 4'd7, 5);
        wait_drain("t2_done", 20);
        check_eq("t2_cnt", 64'(outstd_cnt_o), 64'(1));

        // 3: both requesters contend for four ops
        do_reset();
        @(posedge clk); #1;
`ifdef MEM_ISS_RR_EN
        push_d(MSG_GET_S, 8'h01, 5'h01, 64'h0, 3'd1, 0, 4'd1, 0);
        push_i(64'h0000_0000_0001_0000, 0, 4'd2, 0);
        push_d(MSG_GET_M, 8'h02, 5'h02, 64'h0, 3'd2, 1, 4'd3, 0);
        push_i(64'h0000_0000_0002_0008, 0, 4'd4, 0);
`else
        push_d(MSG_GET_S, 8'h01, 5'h01, 64'h0, 3'd1, 0, 4'd1, 0);
        push_d(MSG_GET_M, 8'h02, 5'h02, 64'h0, 3'd2, 1, 4'd3, 0);
        push_i(64'h0000_0000_0001_0000, 0, 4'd2, 0);
        push_i(64'h0000_0000_0002_0008, 0, 4'd4, 0);
`endif
        wait_drain("t3_done", 60);
        check_eq("t3_cnt", 64'(outstd_cnt_o), 64'(4));

        // 4: fill the outstanding-load budget, then stall and release
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            push_d(MSG_GET_M, 8'(i + 8'h40), 5'(i), 64'h0, 3'(i), 0, 4'((i % 15) + 1), 0);
        end
        wait_drain("t4_fill", 200);
        check_eq("t4_cnt_full", 64'(outstd_cnt_o), 64'(15));
        push_d(MSG_GET_M, 8'h77, 5'h1f, 64'h0, 3'd7, 0, 4'd9, 0);
        repeat (8) @(posedge clk);
        #1;
        check_eq("t4_stall_pending", 64'(exp_q.size()), 64'(1));
        check_eq("t4_stall_bus", 64'(proc2mem_command_o), 64'(BUS_NONE));
        @(negedge clk);
        mem2proc_tag_i = 4'd3;
        @(negedge clk);
        mem2proc_tag_i = '0;
        check_eq("t4_cnt_dec", 64'(outstd_cnt_o), 64'(14));
        @(negedge clk);
        check_eq("t4_issue", 64'(proc2mem_command_o), 64'(BUS_LOAD));
        wait_drain("t4_done", 20);
        check_eq("t4_cnt_refill", 64'(outstd_cnt_o), 64'(15));

        // 5: accept and data return in the same cycle; then a NONE head drains
        do_reset();
        @(posedge clk); #1;
        push_d(MSG_GET_S, 8'h05, 5'h05, 64'h0, 3'd5, 0, 4'd4, 2);
        wait_drain("t5_first", 20);
        check_eq("t5_cnt1", 64'(outstd_cnt_o), 64'(1));
        push_d(MSG_GET_S, 8'h06, 5'h06, 64'h0, 3'd6, 0, 4'd6, 2);
        for (int i = 0; i < 20 && proc2mem_command_o == BUS_NONE; i++) begin
            @(negedge clk);
        end
        check_eq("t5_on_bus", 64'(proc2mem_command_o), 64'(BUS_LOAD));
        mem2proc_tag_i = 4'd2;
        @(negedge clk);
        mem2proc_tag_i = '0;
        wait_drain("t5_second", 20);
        check_eq("t5_cnt_same", 64'(outstd_cnt_o), 64'(1));
        push_d(MSG_NONE, 8'h00, 5'h00, 64'h0, 3'd4, 0, 4'd0, 1);
        wait_drain("t5_drain", 20);
        check_eq("t5_cnt_drain", 64'(outstd_cnt_o), 64'(1));

        // 6: asynchronous reset while the slot is being retried
        push_d(MSG_GET_S, 8'h66, 5'h0c, 64'h0, 3'd1, 1000, 4'd8, 0);
        for (int i = 0; i < 20 && proc2mem_command_o == BUS_NONE; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t6_on_bus", 64'(proc2mem_command_o), 64'(BUS_LOAD));
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_cmd", 64'(proc2mem_command_o), 64'(BUS_NONE));
        check_eq("t6_rst_cnt", 64'(outstd_cnt_o), 64'(0));
        check_eq("t6_rst_ack", 64'(mshr_iss_ack_o), 64'(0));
        if (exp_q.size() > 0) begin
            exp_q[0].rej = 0;
        end
        bus_cyc  = 0;
        rej_done = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_drain("t6_replay", 20);
        check_eq("t6_cnt", 64'(outstd_cnt_o), 64'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
